// File: rtl/tdm_demux4.sv
//------------------------------------------------------------------------------
// Module   : tdm_demux4
// Function : Four-lane TDM demultiplexer with sync-based frame lock.
//            Whole frames are presented atomically on out_a..out_d.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic [1:0]       slot,
  output logic             locked,
  output logic             frame_valid,
  output logic             sync_err
);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_slot, w_slot_nxt;
  logic [WIDTH-1:0] r_sh_a, r_sh_b, r_sh_c;
  logic [WIDTH-1:0] w_sh_a_nxt, w_sh_b_nxt, w_sh_c_nxt;
  logic [WIDTH-1:0] r_out_a, r_out_b, r_out_c, r_out_d;
  logic [WIDTH-1:0] w_out_a_nxt, w_out_b_nxt, w_out_c_nxt, w_out_d_nxt;
  logic             r_frame_valid, w_frame_valid_nxt;
  logic             r_sync_err, w_sync_err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= HUNT;
      r_slot        <= 2'd0;
      r_sh_a        <= '0;
      r_sh_b        <= '0;
      r_sh_c        <= '0;
      r_out_a       <= '0;
      r_out_b       <= '0;
      r_out_c       <= '0;
      r_out_d       <= '0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_slot        <= w_slot_nxt;
      r_sh_a        <= w_sh_a_nxt;
      r_sh_b        <= w_sh_b_nxt;
      r_sh_c        <= w_sh_c_nxt;
      r_out_a       <= w_out_a_nxt;
      r_out_b       <= w_out_b_nxt;
      r_out_c       <= w_out_c_nxt;
      r_out_d       <= w_out_d_nxt;
      r_frame_valid <= w_frame_valid_nxt;
      r_sync_err    <= w_sync_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_slot_nxt        = r_slot;
    w_sh_a_nxt        = r_sh_a;
    w_sh_b_nxt        = r_sh_b;
    w_sh_c_nxt        = r_sh_c;
    w_out_a_nxt       = r_out_a;
    w_out_b_nxt       = r_out_b;
    w_out_c_nxt       = r_out_c;
    w_out_d_nxt       = r_out_d;
    w_frame_valid_nxt = 1'b0;
    w_sync_err_nxt    = 1'b0;

    if (din_valid) begin
      case (r_state)
        HUNT: begin
          if (sync) begin
            w_sh_a_nxt  = din;
            w_slot_nxt  = 2'd1;
            w_state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (sync && (r_slot != 2'd0)) begin
            // Misplaced sync: drop the partial frame and restart at lane a.
            w_sync_err_nxt = 1'b1;
            w_sh_a_nxt     = din;
            w_slot_nxt     = 2'd1;
          end else begin
            case (r_slot)
              2'd0: w_sh_a_nxt = din;
              2'd1: w_sh_b_nxt = din;
              2'd2: w_sh_c_nxt = din;
              default: begin
                // Lane d goes straight to its output; no shadow is needed.
                w_out_a_nxt       = r_sh_a;
                w_out_b_nxt       = r_sh_b;
                w_out_c_nxt       = r_sh_c;
                w_out_d_nxt       = din;
                w_frame_valid_nxt = 1'b1;
              end
            endcase
            w_slot_nxt = r_slot + 2'd1;
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  assign out_a       = r_out_a;
  assign out_b       = r_out_b;
  assign out_c       = r_out_c;
  assign out_d       = r_out_d;
  assign slot        = r_slot;
  assign locked      = (r_state == LOCKED);
  assign frame_valid = r_frame_valid;
  assign sync_err    = r_sync_err;

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux4.sv
//------------------------------------------------------------------------------
// Module   : tb_tdm_demux4
// Function : Directed self-checking bench for tdm_demux4 (WIDTH=1).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tdm_demux4;

  logic       clk;
  logic       rst_n;
  logic [0:0] din;
  logic       din_valid;
  logic       sync;
  logic [0:0] out_a, out_b, out_c, out_d;
  logic [1:0] slot;
  logic       locked;
  logic       frame_valid;
  logic       sync_err;

  int total = 0;
  int bad   = 0;

  tdm_demux4 #(.WIDTH(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .sync       (sync),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_c      (out_c),
    .out_d      (out_d),
    .slot       (slot),
    .locked     (locked),
    .frame_valid(frame_valid),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one beat at the falling edge; leaves the bench 1 ns after the rising edge.
  task automatic beat(input logic s, input logic d);
    @(negedge clk);
    din_valid = 1'b1;
    sync      = s;
    din       = d;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    sync      = 1'b0;
    din       = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_a, out_b, out_c, out_d, slot, locked, frame_valid, sync_err} !== 9'b0) begin
      $display("FAIL reset_state: got outs=%b slot=%0d locked=%b fv=%b serr=%b, need all zero",
               {out_a, out_b, out_c, out_d}, slot, locked, frame_valid, sync_err);
      bad++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_frame();
    apply_reset();
    beat(1'b1, 1'b0);
    total++;
    if (locked !== 1'b1 || slot !== 2'd1) begin
      $display("FAIL basic_lock: got locked=%b slot=%0d, need 1/1", locked, slot);
      bad++;
    end
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b0);
    total++;
    if ({out_a, out_b, out_c, out_d} !== 4'b0000 || frame_valid !== 1'b0) begin
      $display("FAIL basic_partial: got outs=%b fv=%b, need 0000/0", {out_a, out_b, out_c, out_d}, frame_valid);
      bad++;
    end
    beat(1'b0, 1'b1);
    total++;
    if ({out_a, out_b, out_c, out_d} !== 4'b0101 || frame_valid !== 1'b1 ||
        slot !== 2'd0 || locked !== 1'b1) begin
      $display("FAIL basic_frame: got outs=%b fv=%b slot=%0d locked=%b, need 0101/1/0/1",
               {out_a, out_b, out_c, out_d}, frame_valid, slot, locked);
      bad++;
    end
    idle();
    total++;
    if (frame_valid !== 1'b0 || {out_a, out_b, out_c, out_d} !== 4'b0101) begin
      $display("FAIL basic_pulse: got fv=%b outs=%b, need 0/0101", frame_valid, {out_a, out_b, out_c, out_d});
      bad++;
    end
  endtask

  task automatic test_hunt();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      beat(1'b0, 1'b1);
      total++;
      if (locked !== 1'b0 || slot !== 2'd0 || frame_valid !== 1'b0 ||
          {out_a, out_b, out_c, out_d} !== 4'b0000) begin
        $display("FAIL hunt_ignore[%0d]: got locked=%b slot=%0d fv=%b outs=%b, need 0/0/0/0000",
                 i, locked, slot, frame_valid, {out_a, out_b, out_c, out_d});
        bad++;
      end
    end
  endtask

  task automatic test_sync_err();
    apply_reset();
    beat(1'b1, 1'b1); beat(1'b0, 1'b0); beat(1'b0, 1'b0); beat(1'b0, 1'b1);
    total++;
    if ({out_a, out_b, out_c, out_d} !== 4'b1001) begin
      $display("FAIL serr_setup: got outs=%b, need 1001", {out_a, out_b, out_c, out_d});
      bad++;
    end
    beat(1'b1, 1'b1);
    total++;
    if (sync_err !== 1'b0 || slot !== 2'd1) begin
      $display("FAIL serr_slot0_ok: got serr=%b slot=%0d, need 0/1", sync_err, slot);
      bad++;
    end
    beat(1'b0, 1'b1);
    beat(1'b1, 1'b0);
    total++;
    if (sync_err !== 1'b1 || frame_valid !== 1'b0 || slot !== 2'd1 ||
        {out_a, out_b, out_c, out_d} !== 4'b1001) begin
      $display("FAIL serr_pulse: got serr=%b fv=%b slot=%0d outs=%b, need 1/0/1/1001",
               sync_err, frame_valid, slot, {out_a, out_b, out_c, out_d});
      bad++;
    end
    beat(1'b0, 1'b1);
    total++;
    if (sync_err !== 1'b0) begin
      $display("FAIL serr_clear: got serr=%b, need 0", sync_err);
      bad++;
    end
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b0);
    total++;
    if ({out_a, out_b, out_c, out_d} !== 4'b0110 || frame_valid !== 1'b1) begin
      $display("FAIL serr_recover: got outs=%b fv=%b, need 0110/1", {out_a, out_b, out_c, out_d}, frame_valid);
      bad++;
    end
  endtask

  task automatic test_gap();
    int fv_count;
    apply_reset();
    fv_count = 0;
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle();
      total++;
      if (slot !== 2'd2 || frame_valid !== 1'b0 || locked !== 1'b1) begin
        $display("FAIL gap_hold[%0d]: got slot=%0d fv=%b locked=%b, need 2/0/1", i, slot, frame_valid, locked);
        bad++;
      end
    end
    beat(1'b0, 1'b1);
    if (frame_valid === 1'b1) fv_count++;
    beat(1'b0, 1'b1);
    if (frame_valid === 1'b1) fv_count++;
    total++;
    if ({out_a, out_b, out_c, out_d} !== 4'b1011 || frame_valid !== 1'b1) begin
      $display("FAIL gap_frame: got outs=%b fv=%b, need 1011/1", {out_a, out_b, out_c, out_d}, frame_valid);
      bad++;
    end
    // Slot 0 without sync while locked is tolerated.
    beat(1'b0, 1'b0);
    if (frame_valid === 1'b1) fv_count++;
    total++;
    if (fv_count !== 1 || sync_err !== 1'b0 || slot !== 2'd1) begin
      $display("FAIL gap_once: got fv_count=%0d serr=%b slot=%0d, need 1/0/1", fv_count, sync_err, slot);
      bad++;
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    beat(1'b1, 1'b1); beat(1'b0, 1'b1); beat(1'b0, 1'b1); beat(1'b0, 1'b1);
    beat(1'b1, 1'b0); beat(1'b0, 1'b1); beat(1'b0, 1'b1);
    total++;
    if ({out_a, out_b, out_c, out_d} !== 4'b1111 || slot !== 2'd3) begin
      $display("FAIL arst_setup: got outs=%b slot=%0d, need 1111/3", {out_a, out_b, out_c, out_d}, slot);
      bad++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_a, out_b, out_c, out_d} !== 4'b0000 || locked !== 1'b0 || slot !== 2'd0) begin
      $display("FAIL arst_immediate: got outs=%b locked=%b slot=%0d, need 0000/0/0",
               {out_a, out_b, out_c, out_d}, locked, slot);
      bad++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    beat(1'b0, 1'b1);
    beat(1'b1, 1'b1); beat(1'b0, 1'b0); beat(1'b0, 1'b1); beat(1'b0, 1'b0);
    total++;
    if ({out_a, out_b, out_c, out_d} !== 4'b1010 || frame_valid !== 1'b1 || locked !== 1'b1) begin
      $display("FAIL arst_relock: got outs=%b fv=%b locked=%b, need 1010/1/1",
               {out_a, out_b, out_c, out_d}, frame_valid, locked);
      bad++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s_vec;
    logic [7:0] d_vec;
    logic [3:0] exp_out;
    logic       exp_fv;
    s_vec = 8'b0001_0001;   // bit k drives beat k
    d_vec = 8'b0000_0011;   // frame 1 = 0,0,1,1 ; frame 2 = 1,1,0,0
    d_vec[4] = 1'b1; d_vec[5] = 1'b1; d_vec[0] = 1'b0; d_vec[1] = 1'b0; d_vec[2] = 1'b1; d_vec[3] = 1'b1;
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      beat(s_vec[k], d_vec[k]);
      exp_fv  = (k == 3) || (k == 7);
      exp_out = (k < 3) ? 4'b0000 : (k < 7) ? 4'b0011 : 4'b1100;
      total++;
      if (frame_valid !== exp_fv || {out_a, out_b, out_c, out_d} !== exp_out) begin
        $display("FAIL b2b[%0d]: got fv=%b outs=%b, need %b/%b",
                 k, frame_valid, {out_a, out_b, out_c, out_d}, exp_fv, exp_out);
        bad++;
      end
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    din       = 1'b0;
    din_valid = 1'b0;
    sync      = 1'b0;
    test_reset();
    test_basic_frame();
    test_hunt();
    test_sync_err();
    test_gap();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
